// File: rtl/spike_rate_decoder.sv
// Rate-coded output decoder: counts spikes per neuron over a fixed window, then scans for the winner.
// Optional macro SPIKE_DEC_CONT_EN: a completed result handshake immediately starts the next window.
module spike_rate_decoder #(
    parameter int  NUM_OUTPUTS = 2,
    parameter int  WINDOW      = 100,
    parameter int  CNT_W       = 8,
    localparam int IDX_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_OUTPUTS-1:0] spikes_in,
    input  logic                   start,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [IDX_W-1:0]       winner,
    output logic [CNT_W-1:0]       winner_count,
    output logic                   tie
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUTPUTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SCAN,
        REPORT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counts [NUM_OUTPUTS];
    logic [WIN_W-1:0] win_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] run_max;
    logic [IDX_W-1:0] run_idx;
    logic             run_tie;

    logic [CNT_W-1:0] scan_val;
    logic [CNT_W-1:0] nxt_max;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_tie;

    assign scan_val = counts[scan_idx];

    // Next running max including the counter examined this cycle, so the final
    // SCAN cycle can publish the complete result in the same edge.
    always_comb begin
        nxt_max = run_max;
        nxt_idx = run_idx;
        nxt_tie = run_tie;
        if (scan_idx == '0) begin
            nxt_max = scan_val;
            nxt_idx = '0;
            nxt_tie = 1'b0;
        end else if (scan_val > run_max) begin
            nxt_max = scan_val;
            nxt_idx = scan_idx;
            nxt_tie = 1'b0;
        end else if (scan_val == run_max) begin
            nxt_tie = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner       <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
            win_cnt      <= '0;
            scan_idx     <= '0;
            run_max      <= '0;
            run_idx      <= '0;
            run_tie      <= 1'b0;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                counts[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= COUNT;
                        busy    <= 1'b1;
                        win_cnt <= '0;
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            counts[i] <= '0;
                        end
                    end
                end
                COUNT: begin
                    for (int i = 0; i < NUM_OUTPUTS; i++) begin
                        if (spikes_in[i] && (counts[i] != CNT_MAX)) begin
                            counts[i] <= counts[i] + CNT_W'(1);
                        end
                    end
                    if (win_cnt == WIN_LAST) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                SCAN: begin
                    run_max <= nxt_max;
                    run_idx <= nxt_idx;
                    run_tie <= nxt_tie;
                    if (scan_idx == IDX_LAST) begin
                        state        <= REPORT;
                        result_valid <= 1'b1;
                        winner       <= nxt_idx;
                        winner_count <= nxt_max;
                        tie          <= nxt_tie;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                REPORT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
`ifdef SPIKE_DEC_CONT_EN
                        state   <= COUNT;
                        win_cnt <= '0;
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            counts[i] <= '0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: vector table plus hand-written reset/backpressure sequences.
// A second instance with a longer window exercises counter saturation.
module tb_spike_rate_decoder;

    localparam int N     = 2;
    localparam int W     = 10;
    localparam int CW    = 4;
    localparam int W_B   = 20;
    localparam int LAT   = W + N + 1;
    localparam int LAT_B = W_B + N + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  spikes_in;
    logic          start;
    logic          result_ready;
    logic          busy;
    logic          result_valid;
    logic [0:0]    winner;
    logic [CW-1:0] winner_count;
    logic          tie;

    logic [N-1:0]  spikes_b;
    logic          start_b;
    logic          ready_b;
    logic          busy_b;
    logic          valid_b;
    logic [0:0]    winner_b;
    logic [CW-1:0] count_b;
    logic          tie_b;

    always #5 clk = ~clk;

    spike_rate_decoder #(.NUM_OUTPUTS(N), .WINDOW(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .spikes_in(spikes_in), .start(start),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .winner(winner), .winner_count(winner_count), .tie(tie)
    );

    spike_rate_decoder #(.NUM_OUTPUTS(N), .WINDOW(W_B), .CNT_W(CW)) dut_b (
        .clk(clk), .reset(reset), .spikes_in(spikes_b), .start(start_b),
        .busy(busy_b), .result_valid(valid_b), .result_ready(ready_b),
        .winner(winner_b), .winner_count(count_b), .tie(tie_b)
    );

    typedef struct {
        int         mode;
        logic [1:0] a;
        logic [1:0] b;
        int         exp_winner;
        int         exp_count;
        int         exp_tie;
        string      name;
    } vec_t;

    typedef struct {
        int    winner;
        int    count;
        int    tie;
        string name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       last_exp;
    vec_t       tbl [7];
    logic [1:0] rnd_pat [W];
    int         checks = 0;
    int         errors = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [1:0] spike_at(input vec_t v, input int k);
        case (v.mode)
            0:       return v.a;
            1:       return (k % 2 == 0) ? v.a : v.b;
            default: return rnd_pat[k];
        endcase
    endfunction

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Kick a window (start pulse, or a handshake when chaining), drive the
    // spike pattern, then wait a bounded time for the result and score it.
    task automatic apply_stimulus(input vec_t v, input bit kick_by_ready);
        exp_t e;
        int   lat;
        bit   early;
        e.winner = v.exp_winner;
        e.count  = v.exp_count;
        e.tie    = v.exp_tie;
        e.name   = v.name;
        exp_q.push_back(e);
        if (kick_by_ready) result_ready = 1'b1;
        else               start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        result_ready = 1'b0;
        lat          = 1;
        check_output({v.name, "_busy"}, int'(busy), 1);
        early = 1'b0;
        for (int k = 0; k < W; k++) begin
            spikes_in = spike_at(v, k);
            if (k == 3) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (result_valid) early = 1'b1;
        end
        spikes_in = 2'b11;
        while (!result_valid && lat < LAT + 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output({v.name, "_early_valid"}, int'(early), 0);
        check_output({v.name, "_latency"}, lat, LAT);
        if (exp_q.size() == 0) begin
            check_output({v.name, "_queue_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            last_exp = e;
            check_output({e.name, "_winner"}, int'(winner), e.winner);
            check_output({e.name, "_count"}, int'(winner_count), e.count);
            check_output({e.name, "_tie"}, int'(tie), e.tie);
        end
    endtask

    task automatic complete_handshake(input string name);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check_output({name, "_hs_valid"}, int'(result_valid), 0);
`ifdef SPIKE_DEC_CONT_EN
        check_output({name, "_hs_busy"}, int'(busy), 1);
        pulse_reset();
`else
        check_output({name, "_hs_busy"}, int'(busy), 0);
        check_output({name, "_hold_winner"}, int'(winner), last_exp.winner);
        check_output({name, "_hold_count"}, int'(winner_count), last_exp.count);
        check_output({name, "_hold_tie"}, int'(tie), last_exp.tie);
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  lat;
        bit  seen;
        int  c0;
        int  c1;
        vec_t rv;

        tbl[0] = '{0, 2'b10, 2'b00, 1, 10, 0, "const_10"};
        tbl[1] = '{1, 2'b01, 2'b10, 0, 5,  1, "alternate"};
        tbl[2] = '{0, 2'b00, 2'b00, 0, 0,  1, "all_zero"};
        tbl[3] = '{0, 2'b11, 2'b00, 0, 10, 1, "both_full"};
        tbl[4] = '{0, 2'b01, 2'b00, 0, 10, 0, "const_01"};
        tbl[5] = '{1, 2'b10, 2'b00, 1, 5,  0, "half_n1"};
        tbl[6] = '{1, 2'b11, 2'b01, 0, 10, 0, "n0_beats_n1"};

        reset        = 1'b0;
        start        = 1'b0;
        result_ready = 1'b0;
        spikes_in    = '0;
        start_b      = 1'b0;
        ready_b      = 1'b0;
        spikes_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_valid", int'(result_valid), 0);
        check_output("rst_winner", int'(winner), 0);
        check_output("rst_count", int'(winner_count), 0);
        check_output("rst_tie", int'(tie), 0);
        check_output("rst_b_busy", int'(busy_b), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Long window on the second instance: 20 spikes saturate a 4-bit counter.
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b  = 1'b0;
        spikes_b = 2'b01;
        lat      = 1;
        while (!valid_b && lat < LAT_B + 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output("sat_latency", lat, LAT_B);
        check_output("sat_winner", int'(winner_b), 0);
        check_output("sat_count", int'(count_b), 15);
        check_output("sat_tie", int'(tie_b), 0);
        ready_b = 1'b1;
        @(posedge clk);
        #1;
        ready_b = 1'b0;
        check_output("sat_hs_valid", int'(valid_b), 0);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(tbl[i], 1'b0);
            complete_handshake(tbl[i].name);
        end

        for (int r = 0; r < 3; r++) begin
            c0 = 0;
            c1 = 0;
            for (int k = 0; k < W; k++) begin
                rnd_pat[k] = 2'($urandom_range(0, 3));
                c0 += int'(rnd_pat[k][0]);
                c1 += int'(rnd_pat[k][1]);
            end
            if (c0 > 15) c0 = 15;
            if (c1 > 15) c1 = 15;
            rv.mode = 2;
            rv.a    = 2'b00;
            rv.b    = 2'b00;
            rv.name = $sformatf("random_%0d", r);
            if (c1 > c0) begin
                rv.exp_winner = 1;
                rv.exp_count  = c1;
                rv.exp_tie    = 0;
            end else begin
                rv.exp_winner = 0;
                rv.exp_count  = c0;
                rv.exp_tie    = (c0 == c1) ? 1 : 0;
            end
            apply_stimulus(rv, 1'b0);
            complete_handshake(rv.name);
        end

        // Backpressure: result must hold while ready is low; start is not queued.
        apply_stimulus(tbl[0], 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check_output($sformatf("bp_valid_%0d", c), int'(result_valid), 1);
            check_output($sformatf("bp_winner_%0d", c), int'(winner), last_exp.winner);
            check_output($sformatf("bp_count_%0d", c), int'(winner_count), last_exp.count);
            check_output($sformatf("bp_tie_%0d", c), int'(tie), last_exp.tie);
        end
        complete_handshake("backpressure");

        // Reset in the fourth COUNT cycle aborts the window.
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        spikes_in = 2'b10;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_valid", int'(result_valid), 0);
        check_output("abort_winner", int'(winner), 0);
        check_output("abort_count", int'(winner_count), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (result_valid) seen = 1'b1;
        end
        check_output("abort_no_result", int'(seen), 0);
        check_output("abort_idle", int'(busy), 0);
        apply_stimulus(tbl[1], 1'b0);
`ifdef SPIKE_DEC_CONT_EN
        apply_stimulus(tbl[0], 1'b1);
        complete_handshake("chained");
`else
        complete_handshake("after_abort");
`endif

        check_output("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
